// File: rtl/param_shift_register.sv
// param_shift_register: loadable right-shift register with a saturating shift
// counter. It raises done after MAX_SHIFTS shifts, so a controller can step a
// sequential multiplier without keeping its own bit count.
// Optional feature: define SHIFT_SERIAL_IN_EN to add the ser_in port. The bit
// on ser_in fills the MSB on each shift. Without the macro the fill is 1'b0.
module param_shift_register #(
    parameter int WIDTH      = 4,
    parameter int MAX_SHIFTS = WIDTH,
    parameter int CNT_W      = $clog2(MAX_SHIFTS + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             shb,
    input  logic [WIDTH-1:0] data_in,
`ifdef SHIFT_SERIAL_IN_EN
    input  logic             ser_in,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SHIFTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic             fill;
    logic [CNT_W-1:0] cnt_next;

`ifdef SHIFT_SERIAL_IN_EN
    assign fill = ser_in;
`else
    assign fill = 1'b0;
`endif

    assign cnt_next = shift_cnt + 1'b1;

    // Control and datapath update: the priority is clr, then ld, then shb.
    // Shifting happens only while busy. This keeps the counter from wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            data_out  <= '0;
            bit_out   <= 1'b0;
            shift_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ld) begin
            state     <= S_BUSY;
            data_out  <= data_in;
            bit_out   <= 1'b0;
            shift_cnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (shb && state == S_BUSY) begin
            data_out  <= {fill, data_out[WIDTH-1:1]};
            bit_out   <= data_out[0];
            shift_cnt <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed testbench for param_shift_register with WIDTH=4.
module tb_param_shift_register;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ld  = 1'b0;
    logic       shb = 1'b0;
    logic [3:0] data_in = '0;
`ifdef SHIFT_SERIAL_IN_EN
    logic       ser_in = 1'b0;
`endif
    logic [3:0] data_out;
    logic       bit_out;
    logic [2:0] shift_cnt;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    param_shift_register #(.WIDTH(4), .MAX_SHIFTS(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .ld        (ld),
        .shb       (shb),
        .data_in   (data_in),
`ifdef SHIFT_SERIAL_IN_EN
        .ser_in    (ser_in),
`endif
        .data_out  (data_out),
        .bit_out   (bit_out),
        .shift_cnt (shift_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic c, input logic l, input logic s, input logic [3:0] d);
        clr = c; ld = l; shb = s; data_in = d;
        @(posedge clk);
        #1;
        clr = 1'b0; ld = 1'b0; shb = 1'b0;
    endtask

    // Compares every output against the expected values.
    task automatic check_all(input string tag, input logic [3:0] e_data, input logic e_bit,
                             input logic [2:0] e_cnt, input logic e_busy, input logic e_done);
        checks++;
        assert ({data_out, bit_out, shift_cnt, busy, done} === {e_data, e_bit, e_cnt, e_busy, e_done})
        else begin
            errors++;
            $error("FAIL %s: observed data=%b bit=%b cnt=%0d busy=%b done=%b expected data=%b bit=%b cnt=%0d busy=%b done=%b",
                   tag, data_out, bit_out, shift_cnt, busy, done, e_data, e_bit, e_cnt, e_busy, e_done);
        end
    endtask

    initial begin
        // Reset wins over ld and shb.
        cyc(1, 1, 1, 4'b1010); check_all("reset",       4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 1, 4'b0000); check_all("idle_shb",    4'b0000, 0, 0, 0, 0);

        // Load, then four shifts.
        cyc(0, 1, 0, 4'b1011); check_all("load_1011",   4'b1011, 0, 0, 1, 0);
        cyc(0, 0, 0, 4'b0000); check_all("hold",        4'b1011, 0, 0, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("shift1",      4'b0101, 1, 1, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("shift2",      4'b0010, 1, 2, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("shift3",      4'b0001, 0, 3, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("shift4_done", 4'b0000, 1, 4, 0, 1);

        // Once done, further shifts change nothing and the counter saturates.
        cyc(0, 0, 1, 4'b0000); check_all("post_done1",  4'b0000, 1, 4, 0, 1);
        cyc(0, 0, 1, 4'b0000); check_all("post_done2",  4'b0000, 1, 4, 0, 1);

        // ld has priority over shb on the same edge.
        cyc(0, 1, 1, 4'b1100); check_all("ld_shb_same", 4'b1100, 0, 0, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("shift_1100",  4'b0110, 0, 1, 1, 0);

        // ld while busy aborts and restarts. clr mid-operation clears everything.
        cyc(0, 1, 0, 4'b1111); check_all("reload_1111", 4'b1111, 0, 0, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("f_shift1",    4'b0111, 1, 1, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("f_shift2",    4'b0011, 1, 2, 1, 0);
        cyc(1, 0, 0, 4'b0000); check_all("mid_clr",     4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 1, 4'b0000); check_all("shb_no_ld",   4'b0000, 0, 0, 0, 0);

`ifdef SHIFT_SERIAL_IN_EN
        // Serial fill feeds the MSB.
        cyc(0, 1, 0, 4'b0000); check_all("ser_load",    4'b0000, 0, 0, 1, 0);
        ser_in = 1'b1;
        cyc(0, 0, 1, 4'b0000); check_all("ser1",        4'b1000, 0, 1, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("ser2",        4'b1100, 0, 2, 1, 0);
        cyc(0, 0, 1, 4'b0000); check_all("ser3",        4'b1110, 0, 3, 1, 0);
        ser_in = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
